// File: rtl/i2c_target_regs.sv
`timescale 1ns/1ps
// I2C target bridging an external initiator to an 8-bit-addressed register space.
// scl/sda are oversampled on clk; sda is answered through an open-drain pull-down.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_drv_low,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WDATA, RDATA, RACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rw_q, rw_d;
  logic       sda_drv_low_q, sda_drv_low_d;
  logic       wr_en_q, wr_en_d;
  logic       rd_en_q, rd_en_d;
  logic       busy_q, busy_d;
  logic [7:0] byte_in;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  // Bus conditions require scl stably high on both sides of the sda edge.
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

  assign byte_in = {shift_q[6:0], sda_s};

  // Bit counter: 0..7 while shifting a byte, 8 = byte done (ACK pending), 9 = ACK driven.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    scl_sync_d    = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d    = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    reg_addr_d    = reg_addr_q;
    wr_data_d     = wr_data_q;
    rw_d          = rw_q;
    sda_drv_low_d = sda_drv_low_q;
    wr_en_d       = 1'b0;
    rd_en_d       = 1'b0;
    busy_d        = busy_q;

    if (wr_en_q) reg_addr_d = reg_addr_q + 8'd1;

    if (start_det) begin
      state_d       = ADDR;
      bit_cnt_d     = 4'd0;
      sda_drv_low_d = 1'b0;
      busy_d        = 1'b1;
    end else if (stop_det) begin
      state_d       = IDLE;
      bit_cnt_d     = 4'd0;
      sda_drv_low_d = 1'b0;
      busy_d        = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, WAIT_STOP: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rw_d    = sda_s;
              state_d = (byte_in[7:1] == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_drv_low_d = 1'b1;
              bit_cnt_d     = 4'd9;
            end else begin
              sda_drv_low_d = 1'b0;
              bit_cnt_d     = 4'd0;
              rd_en_d       = rw_q;
              state_d       = rw_q ? RDATA : PTR;
            end
          end
        end
        PTR, WDATA: begin
          if (bit_cnt_q < 4'd8) begin
            if (scl_rise) begin
              shift_d   = byte_in;
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                if (state_q == PTR) begin
                  reg_addr_d = byte_in;
                end else begin
                  wr_data_d = byte_in;
                  wr_en_d   = 1'b1;
                end
              end
            end
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_drv_low_d = 1'b1;
              bit_cnt_d     = 4'd9;
            end else begin
              sda_drv_low_d = 1'b0;
              bit_cnt_d     = 4'd0;
              state_d       = WDATA;
            end
          end
        end
        RDATA: begin
          // rd_data is valid the clk after rd_en; bit 7 goes out while scl is still low.
          if (rd_en_q) begin
            shift_d       = rd_data;
            sda_drv_low_d = ~rd_data[7];
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_drv_low_d = 1'b0;
              bit_cnt_d     = 4'd0;
              state_d       = RACK;
            end else begin
              sda_drv_low_d = ~shift_q[6];
              shift_d       = {shift_q[6:0], 1'b0};
              bit_cnt_d     = bit_cnt_q + 4'd1;
            end
          end
        end
        RACK: begin
          if (bit_cnt_q == 4'd0) begin
            if (scl_rise) begin
              if (!sda_s) begin
                reg_addr_d = reg_addr_q + 8'd1;
                bit_cnt_d  = 4'd1;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end else if (scl_fall) begin
            rd_en_d   = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = RDATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Synchronizers reset to the idle bus level so reset release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q    <= '1;
      sda_sync_q    <= '1;
      scl_hist_q    <= 1'b1;
      sda_hist_q    <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      reg_addr_q    <= 8'h00;
      wr_data_q     <= 8'h00;
      rw_q          <= 1'b0;
      sda_drv_low_q <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      scl_sync_q    <= scl_sync_d;
      sda_sync_q    <= sda_sync_d;
      scl_hist_q    <= scl_s;
      sda_hist_q    <= sda_s;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      reg_addr_q    <= reg_addr_d;
      wr_data_q     <= wr_data_d;
      rw_q          <= rw_d;
      sda_drv_low_q <= sda_drv_low_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      busy_q        <= busy_d;
    end
  end

  assign sda_drv_low = sda_drv_low_q;
  assign reg_addr    = reg_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign busy        = busy_q;

endmodule
